vid_capture: RTL
================

Name: vid_capture

Overview:
- Sink-side counterpart of the emulator core's video output: consumes the pixel stream (R/G/B, HS/VS, HB/VB, CE_PIXEL) that the core drives to the simulation harness.
- Reconstructs pixel coordinates and writes active pixels into a framebuffer through a valid/ready write port.
- Measures active width/height per frame and flags clipping and overflow.
- Sits between the emu video outputs and the harness/display memory.

Parameters:
- MAX_W, 1024, framebuffer line pitch in pixels; power of 2.
- MAX_H, 512, maximum captured lines; power of 2.
- FIFO_DEPTH, 16, pixel write FIFO entries; power of 2, minimum 2.
- ADDR_W, 19, framebuffer address width; must be at least log2(MAX_W*MAX_H).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce_pix  in  1  pixel clock enable; inputs are sampled only when high.
- r, g, b  in  8 each  pixel colour.
- hblank, vblank  in  1 each  blanking flags.
- hsync, vsync  in  1 each  sync; used only for status.
- fb_wr_valid  out  1  write request.
- fb_wr_ready  in  1  framebuffer accepts the write.
- fb_wr_addr  out  ADDR_W  y*MAX_W + x.
- fb_wr_data  out  24  {r,g,b}.
- frame_done  out  1  one-cycle pulse at end of frame.
- active_w  out  11  last complete frame width.
- active_h  out  10  last complete frame height.
- frame_count  out  16  completed frames; wraps.
- clip  out  1  sticky: a pixel was dropped because it was out of range.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- clr_status  in  1  clears clip and overflow.
- frame_crc  out  32  CRC of the last frame; see Optional Feature.

Behaviour:
- Reset: all outputs 0, FIFO empty, x=y=0, state SYNC.
- Edge detection:
  - Edge detectors use the previous sampled hblank/vblank, updated only on ce_pix cycles.
  - Reset value of the previous flags is 1, so no false edge occurs after reset.
- State SYNC: ignore pixels; on a vblank falling edge (ce_pix) go to FRAME with x=y=0. No frame_done is issued for the partial frame after reset.
- State FRAME, on each ce_pix cycle:
  - Active pixel (hblank=0, vblank=0):
    - If x<MAX_W and y<MAX_H: push {addr,rgb} unless the FIFO is full. If full, drop the pixel and set overflow.
    - If x>=MAX_W or y>=MAX_H: drop the pixel and set clip.
    - x increments saturating at 2047 regardless of drop.
  - hblank rising edge with x>0: line_w=x; y++ (saturating at 1023); x=0.
  - vblank rising edge:
    - Pending line: y_final = y + (x>0).
    - active_w = line_w, or x if a line is pending.
    - active_h = y_final.
    - frame_done pulses the next cycle; frame_count++; x=y=0.
    - Stay in FRAME.
  - Simultaneous hblank and vblank rising: the vblank rule applies and covers the pending line; no double-count.
- FIFO:
  - fb_wr_valid = FIFO not empty.
  - Pop when fb_wr_valid && fb_wr_ready.
  - fb_wr_addr/data stable while valid && !ready.
  - Push and pop in the same cycle are both allowed when full.
  - Latency: a pixel sampled at cycle N is presented at N+1 if the FIFO was empty.
- clr_status has priority over a same-cycle set.
- Reset asserted mid-frame: FIFO is flushed and the block returns to SYNC immediately (asynchronous).
- Width rules: addr = {y[log2 MAX_H-1:0], x[log2 MAX_W-1:0]}, zero-extended to ADDR_W.

Optional Feature:
- Macro VID_CAPTURE_CRC_EN.
- When defined:
  - CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, final xor 0xFFFFFFFF) runs over the 24-bit rgb of every in-range active pixel, whether or not it was dropped for overflow.
  - frame_crc updates on the same cycle as frame_done.
  - The running CRC reinitialises at each frame start.
- When undefined: frame_crc is tied to 0 and no CRC logic exists.

Decomposition:
- Package vid_capture_pkg:
  - pixel_t (24-bit packed r,g,b).
  - state enum {SYNC, FRAME}.
  - CRC32_POLY and CRC32_INIT constants.
- Sub-module vid_capture_fifo: synchronous FWFT FIFO, parameterised width/depth, with full/empty/push/pop.

Test Plan:
- 4x3 active frame, ce_pix=1, ready=1 → 12 writes with addr 0..3, 1024..1027, 2048..2051; frame_done once; active_w=4, active_h=3.
- Stream started mid-frame after reset → no writes and no frame_done until the first vblank falling edge; frame_count=1 after the first full frame.
- fb_wr_ready=0 for 20 pixels, FIFO_DEPTH=16 → 16 entries held, overflow=1, addr/data stable; ready=1 drains entries in order; clr_status clears overflow.
- MAX_W=1024, 1030-pixel line → 1024 writes, clip=1, active_w=1030.
- ce_pix every 4th cycle, 2x2 frame → pixels only on enable cycles; final line ends at a simultaneous hblank/vblank rise → active_h=2, one frame_done.
- With VID_CAPTURE_CRC_EN, 1x1 frame rgb=0x000000 → frame_crc equals the reference CRC-32 of bytes 00 00 00 (0xFF41D912); without the macro frame_crc=0.

Source files
------------

// File: rtl/vid_capture_pkg.sv
// Shared types and CRC helpers for the video capture sink.
// The CRC helper is only referenced when VID_CAPTURE_CRC_EN is defined.
package vid_capture_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic {
        SYNC,
        FRAME
    } state_t;

    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    // Reflected CRC-32 over the bytes r, g, b, each shifted in LSB first.
    function automatic logic [31:0] crc32_pixel(input logic [31:0] crc, input pixel_t p);
        logic [31:0] c;
        logic [31:0] poly_r;
        logic [23:0] d;
        for (int i = 0; i < 32; i++) begin
            poly_r[5'(i)] = CRC32_POLY[5'(31 - i)];
        end
        c = crc;
        d = {p.b, p.g, p.r};
        for (int i = 0; i < 24; i++) begin
            c = (c[0] ^ d[5'(i)]) ? ((c >> 1) ^ poly_r) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/vid_capture_if.sv
// Framebuffer write port: valid/ready handshake carrying address and pixel.
interface vid_capture_if #(
    parameter int unsigned ADDR_W = 19
) ();
    import vid_capture_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    pixel_t            wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vid_capture_fifo.sv
// First-word-fall-through FIFO; dout shows the head entry whenever empty is low.
module vid_capture_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_ok_c  = pop & ~empty;
    // A pop frees the slot the same-cycle push lands in, so full does not block it.
    assign push_ok_c = push & (~full | pop_ok_c);
    assign dout      = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok_c) - (AW+1)'(pop_ok_c);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vid_capture.sv
// Video stream sink: rebuilds pixel coordinates, queues active pixels to the framebuffer,
// and measures each frame. Define VID_CAPTURE_CRC_EN to enable the per-frame CRC-32.
module vid_capture
    import vid_capture_pkg::*;
#(
    parameter int unsigned MAX_W      = 1024,
    parameter int unsigned MAX_H      = 512,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [7:0]    r,
    input  logic [7:0]    g,
    input  logic [7:0]    b,
    input  logic          hblank,
    input  logic          vblank,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          clr_status,
    vid_capture_if.master fb,
    output logic          frame_done,
    output logic [10:0]   active_w,
    output logic [9:0]    active_h,
    output logic [15:0]   frame_count,
    output logic          clip,
    output logic          overflow,
    output logic [31:0]   frame_crc
);
    localparam int unsigned XW      = $clog2(MAX_W);
    localparam int unsigned YW      = $clog2(MAX_H);
    localparam int unsigned ENTRY_W = ADDR_W + 24;
    localparam logic [10:0] X_SAT   = 11'h7FF;
    localparam logic [9:0]  Y_SAT   = 10'h3FF;

    state_t              state;
    logic [10:0]         x;
    logic [10:0]         line_w;
    logic [9:0]          y;
    logic                prev_hb;
    logic                prev_vb;
    logic                primed;

    logic                hb_rise_c;
    logic                vb_rise_c;
    logic                vb_fall_c;
    logic                frame_start_c;
    logic                frame_end_c;
    logic                pix_active_c;
    logic                in_range_c;
    logic                pix_keep_c;
    logic                push_c;
    logic                pop_c;
    logic                pending_c;
    logic [9:0]          y_final_c;
    pixel_t              pix_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [ENTRY_W-1:0]  fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                unused_sync;

    // Sync inputs are carried for status only and feed nothing yet.
    assign unused_sync = hsync ^ vsync;

    assign hb_rise_c     = ce_pix & hblank & ~prev_hb;
    assign vb_rise_c     = ce_pix & vblank & ~prev_vb;
    // A falling edge needs one real sample first, so a stream already mid-frame is not taken as a frame start.
    assign vb_fall_c     = ce_pix & primed & prev_vb & ~vblank;
    assign frame_start_c = (state == SYNC) & vb_fall_c;
    assign frame_end_c   = (state == FRAME) & vb_rise_c;
    assign pix_active_c  = (state == FRAME) & ce_pix & ~hblank & ~vblank;
    assign in_range_c    = (32'(x) < MAX_W) && (32'(y) < MAX_H);
    assign pix_keep_c    = pix_active_c & in_range_c;
    assign pop_c         = ~fifo_empty & fb.wr_ready;
    assign push_c        = pix_keep_c & (~fifo_full | pop_c);
    assign pending_c     = (x != '0);
    assign y_final_c     = (pending_c && y != Y_SAT) ? y + 10'd1 : y;
    assign pix_c         = {r, g, b};
    assign addr_c        = ADDR_W'({y[YW-1:0], x[XW-1:0]});

    vid_capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .push  (push_c),
        .din   ({addr_c, pix_c}),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fb.wr_valid = ~fifo_empty;
    assign {fb.wr_addr, fb.wr_data} = fifo_dout;

    // Frame tracking FSM with coordinate counters and measurement registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= SYNC;
            x           <= '0;
            y           <= '0;
            line_w      <= '0;
            prev_hb     <= 1'b1;
            prev_vb     <= 1'b1;
            primed      <= 1'b0;
            frame_done  <= 1'b0;
            active_w    <= '0;
            active_h    <= '0;
            frame_count <= '0;
            clip        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (ce_pix) begin
                prev_hb <= hblank;
                prev_vb <= vblank;
                primed  <= 1'b1;
            end
            case (state)
                SYNC: begin
                    if (frame_start_c) begin
                        state  <= FRAME;
                        x      <= '0;
                        y      <= '0;
                        line_w <= '0;
                    end
                end
                FRAME: begin
                    // vblank wins over a coincident hblank edge and absorbs the unfinished line.
                    if (frame_end_c) begin
                        active_w    <= pending_c ? x : line_w;
                        active_h    <= y_final_c;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        x           <= '0;
                        y           <= '0;
                        line_w      <= '0;
                    end else if (hb_rise_c && pending_c) begin
                        line_w <= x;
                        y      <= (y == Y_SAT) ? y : y + 10'd1;
                        x      <= '0;
                    end else if (pix_active_c) begin
                        x <= (x == X_SAT) ? x : x + 11'd1;
                    end
                end
                default: state <= SYNC;
            endcase
            if (clr_status) begin
                clip     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (pix_active_c && !in_range_c) clip     <= 1'b1;
                if (pix_keep_c && !push_c)       overflow <= 1'b1;
            end
        end
    end

`ifdef VID_CAPTURE_CRC_EN
    logic [31:0] crc_run;

    // Running CRC covers every in-range pixel, including ones the full FIFO turned away.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            crc_run   <= CRC32_INIT;
            frame_crc <= '0;
        end else if (pix_keep_c) begin
            crc_run <= crc32_pixel(crc_run, pix_c);
        end else if (frame_start_c || frame_end_c) begin
            crc_run <= CRC32_INIT;
            if (frame_end_c) frame_crc <= crc_run ^ CRC32_XOROUT;
        end
    end
`else
    assign frame_crc = '0;
`endif

endmodule
